// File: rtl/regfile_wb_arbiter_if.sv
// Write-port arbitration bus: WB and mul/div requesters, register file write
// port, and the PENDING / ERR_WAW status towards decode.
interface regfile_wb_arbiter_if;
  logic        WB_VALID;
  logic [4:0]  WB_ADDR;
  logic [31:0] WB_DATA;
  logic        WB_READY;
  logic        MD_VALID;
  logic [4:0]  MD_ADDR;
  logic [31:0] MD_DATA;
  logic        MD_READY;
  logic        WRITEENABLE;
  logic [4:0]  WRITEADDRESS;
  logic [31:0] WRITEDATA;
  logic [31:0] PENDING;
  logic        ERR_WAW;

  // Pipeline / environment side
  modport master (
    output WB_VALID, WB_ADDR, WB_DATA, MD_VALID, MD_ADDR, MD_DATA,
    input  WB_READY, MD_READY, WRITEENABLE, WRITEADDRESS, WRITEDATA,
           PENDING, ERR_WAW
  );

  // Arbiter side
  modport slave (
    input  WB_VALID, WB_ADDR, WB_DATA, MD_VALID, MD_ADDR, MD_DATA,
    output WB_READY, MD_READY, WRITEENABLE, WRITEADDRESS, WRITEDATA,
           PENDING, ERR_WAW
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter: WB stage has default priority, mul/div
// results are queued in a DEPTH-entry FIFO, and a starvation counter hands the
// port to the FIFO head after STARVE_LIMIT consecutive losses.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  regfile_wb_arbiter_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

  typedef enum logic {WB_PRI, MD_PRI} state_t;

  state_t          state;
  logic [SW-1:0]   starve;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [4:0]      fifo_addr [DEPTH];
  logic [31:0]     fifo_data [DEPTH];
  logic            err_waw;

  logic            empty;
  logic            full;
  logic            wb_eff;
  logic            grant_wb;
  logic            grant_md;
  logic            wb_ready;
  logic            md_ready;
  logic            push;
  logic [31:0]     pend;
  logic [AW-1:0]   off;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign wb_eff = bus.WB_VALID && (bus.WB_ADDR != 5'd0);

  // Grant selection for the current cycle; everything is held off in reset
  always_comb begin
    grant_wb = 1'b0;
    grant_md = 1'b0;
    wb_ready = 1'b1;
    if (!RESET) begin
      case (state)
        WB_PRI: begin
          if (wb_eff)      grant_wb = 1'b1;
          else if (!empty) grant_md = 1'b1;
        end
        MD_PRI: begin
          grant_md = !empty;
          wb_ready = !wb_eff;
        end
        default: ;
      endcase
    end
  end

  assign md_ready = !RESET && !full;
  // x0 results complete the handshake but are never queued
  assign push     = bus.MD_VALID && md_ready && (bus.MD_ADDR != 5'd0);

  // Pending-register mask over the live FIFO entries
  always_comb begin
    pend = '0;
    off  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr;
      if (CW'(off) < count)
        pend = pend | (32'd1 << fifo_addr[i]);
    end
    pend[0] = 1'b0;
  end

  // Write-port and handshake outputs
  always_comb begin
    bus.WRITEENABLE  = grant_wb || grant_md;
    bus.WRITEADDRESS = '0;
    bus.WRITEDATA    = '0;
    if (grant_wb) begin
      bus.WRITEADDRESS = bus.WB_ADDR;
      bus.WRITEDATA    = bus.WB_DATA;
    end else if (grant_md) begin
      bus.WRITEADDRESS = fifo_addr[rd_ptr];
      bus.WRITEDATA    = fifo_data[rd_ptr];
    end
    bus.WB_READY = wb_ready;
    bus.MD_READY = md_ready;
    bus.PENDING  = RESET ? '0 : pend;
    bus.ERR_WAW  = err_waw;
  end

  // FIFO payload storage; no reset needed, validity comes from count
  always_ff @(posedge CLK) begin
    if (!RESET && push) begin
      fifo_addr[wr_ptr] <= bus.MD_ADDR;
      fifo_data[wr_ptr] <= bus.MD_DATA;
    end
  end

  // Priority FSM, starvation counter, FIFO pointers and WAW flag
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= WB_PRI;
      starve  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      err_waw <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + AW'(1);
      if (grant_md) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(grant_md);

      if (grant_wb && pend[bus.WB_ADDR])
        err_waw <= 1'b1;

      // MD_PRI always grants the head, so it lasts exactly one cycle
      if (state == MD_PRI)
        state <= WB_PRI;

      if (empty || grant_md) begin
        starve <= '0;
      end else if (starve == SW'(STARVE_LIMIT - 1)) begin
        starve <= '0;
        state  <= MD_PRI;
      end else begin
        starve <= starve + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a queue of expected FIFO writes.
module tb_regfile_wb_arbiter;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int          nchecks = 0;
  int          nerr    = 0;
  logic [36:0] expq [$];
  logic [31:0] rf [32];
  logic [4:0]  wa;
  logic [31:0] wd;

  // Register file driven by the arbiter's write port
  always_ff @(posedge CLK)
    if (bus.WRITEENABLE) rf[bus.WRITEADDRESS] <= bus.WRITEDATA;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.WB_VALID = v;
    bus.WB_ADDR  = a;
    bus.WB_DATA  = d;
    wa = a;
    wd = d;
  endtask

  task automatic drive_md(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.MD_VALID = v;
    bus.MD_ADDR  = a;
    bus.MD_DATA  = d;
  endtask

  // MD transfer expected to be queued and written later in order
  task automatic md_push(input logic [4:0] a, input logic [31:0] d);
    drive_md(1'b1, a, d);
    expq.push_back({a, d});
  endtask

  // kind 0: no write, 1: WB write of driven fields, 2: next queued MD write
  task automatic port(input string tag, input int kind);
    logic [36:0] e;
    if (kind == 0) begin
      chk({tag, "_we"},   32'(bus.WRITEENABLE),  32'd0);
      chk({tag, "_addr"}, 32'(bus.WRITEADDRESS), 32'd0);
      chk({tag, "_data"}, bus.WRITEDATA,         32'd0);
    end else if (kind == 1) begin
      chk({tag, "_we"},   32'(bus.WRITEENABLE),  32'd1);
      chk({tag, "_addr"}, 32'(bus.WRITEADDRESS), 32'(wa));
      chk({tag, "_data"}, bus.WRITEDATA,         wd);
    end else begin
      if (expq.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = expq.pop_front();
        chk({tag, "_we"},   32'(bus.WRITEENABLE),  32'd1);
        chk({tag, "_addr"}, 32'(bus.WRITEADDRESS), 32'(e[36:32]));
        chk({tag, "_data"}, bus.WRITEDATA,         e[31:0]);
      end
    end
  endtask

  initial begin
    // Reset with MD_VALID asserted
    RESET = 1'b1;
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_md(1'b1, 5'd7, 32'hDEAD0007);
    #2;
    chk("rst_we", 32'(bus.WRITEENABLE), 32'd0);
    chk("rst_mdr", 32'(bus.MD_READY), 32'd0);
    chk("rst_pend", bus.PENDING, 32'd0);
    chk("rst_wbr", 32'(bus.WB_READY), 32'd1);
    cyc(); #2;
    chk("rst2_we", 32'(bus.WRITEENABLE), 32'd0);
    chk("rst2_mdr", 32'(bus.MD_READY), 32'd0);
    cyc();
    RESET = 1'b0;
    drive_md(1'b0, 5'd0, 32'd0);
    #2;
    chk("rel_mdr", 32'(bus.MD_READY), 32'd1);
    chk("rel_pend", bus.PENDING, 32'd0);
    chk("rel_err", 32'(bus.ERR_WAW), 32'd0);
    port("rel", 0);

    // WB only
    cyc(); drive_wb(1'b1, 5'd5, 32'hA5A5A5A5); #2;
    port("wb_x5", 1);
    chk("wb_x5_rdy", 32'(bus.WB_READY), 32'd1);
    cyc(); drive_wb(1'b0, 5'd0, 32'd0); #2;
    chk("rf_x5", rf[5], 32'hA5A5A5A5);
    port("idle0", 0);

    // Idle-slot drain
    cyc(); md_push(5'd7, 32'h12345678); #2;
    port("push7", 0);
    chk("push7_mdr", 32'(bus.MD_READY), 32'd1);
    cyc(); drive_md(1'b0, 5'd0, 32'd0); #2;
    chk("drain_pend", bus.PENDING, 32'h0000_0080);
    port("drain_x7", 2);
    cyc(); #2;
    chk("drain_pend0", bus.PENDING, 32'd0);
    port("drain_idle", 0);

    // Starvation: fill with x3, x4 while WB writes x9 every cycle
    cyc(); drive_wb(1'b1, 5'd9, 32'h9000_0000); md_push(5'd3, 32'h33333333); #2;
    port("st_wb0", 1);
    chk("st_mdr0", 32'(bus.MD_READY), 32'd1);
    cyc(); drive_wb(1'b1, 5'd9, 32'h9000_0001); md_push(5'd4, 32'h44444444); #2;
    port("st_wb1", 1);
    chk("st_mdr1", 32'(bus.MD_READY), 32'd1);
    chk("st_pend1", bus.PENDING, 32'h0000_0008);
    cyc(); drive_md(1'b0, 5'd0, 32'd0); drive_wb(1'b1, 5'd9, 32'h9000_0002); #2;
    port("st_wb2", 1);
    chk("st_full_mdr", 32'(bus.MD_READY), 32'd0);
    chk("st_pend2", bus.PENDING, 32'h0000_0018);
    for (int k = 3; k <= 4; k++) begin
      cyc(); drive_wb(1'b1, 5'd9, 32'h9000_0000 + 32'(k)); #2;
      port("st_wbA", 1);
      chk("st_wbA_rdy", 32'(bus.WB_READY), 32'd1);
    end
    cyc(); #2;
    chk("st_hold_rdy", 32'(bus.WB_READY), 32'd0);
    chk("st_hold_mdr", 32'(bus.MD_READY), 32'd0);
    port("st_md_x3", 2);
    for (int k = 0; k < 4; k++) begin
      cyc(); drive_wb(1'b1, 5'd9, 32'h9100_0000 + 32'(k)); #2;
      port("st_wbB", 1);
      chk("st_wbB_rdy", 32'(bus.WB_READY), 32'd1);
      if (k == 0) begin
        chk("st_pop_mdr", 32'(bus.MD_READY), 32'd1);
        chk("st_pend_x4", bus.PENDING, 32'h0000_0010);
      end
    end
    cyc(); #2;
    chk("st_hold2_rdy", 32'(bus.WB_READY), 32'd0);
    port("st_md_x4", 2);
    cyc(); drive_wb(1'b0, 5'd0, 32'd0); #2;
    port("st_idle", 0);
    chk("st_pend0", bus.PENDING, 32'd0);

    // x0 handling
    cyc(); drive_md(1'b1, 5'd0, 32'h0BAD0000); #2;
    chk("x0_mdr", 32'(bus.MD_READY), 32'd1);
    port("x0_push", 0);
    cyc(); drive_md(1'b0, 5'd0, 32'd0); #2;
    chk("x0_pend", bus.PENDING, 32'd0);
    port("x0_none", 0);
    cyc(); md_push(5'd6, 32'h66666666); #2;
    port("push6", 0);
    cyc(); drive_md(1'b0, 5'd0, 32'd0); drive_wb(1'b1, 5'd0, 32'hFFFFFFFF); #2;
    chk("wb0_rdy", 32'(bus.WB_READY), 32'd1);
    chk("wb0_pend", bus.PENDING, 32'h0000_0040);
    port("wb0_x6", 2);
    cyc(); drive_wb(1'b0, 5'd0, 32'd0); #2;
    chk("wb0_pend0", bus.PENDING, 32'd0);
    port("wb0_idle", 0);

    // Duplicate address and push+pop in the same cycle
    cyc(); drive_wb(1'b1, 5'd9, 32'h9200_0000); md_push(5'd20, 32'h2000_000A); #2;
    port("dup_wb0", 1);
    cyc(); drive_wb(1'b1, 5'd9, 32'h9200_0001); md_push(5'd20, 32'h2000_000B); #2;
    port("dup_wb1", 1);
    chk("dup_pend1", bus.PENDING, 32'h0010_0000);
    cyc(); drive_wb(1'b0, 5'd0, 32'd0); drive_md(1'b0, 5'd0, 32'd0); #2;
    port("dup_popA", 2);
    chk("dup_pend2", bus.PENDING, 32'h0010_0000);
    cyc(); md_push(5'd22, 32'h2200_000C); #2;
    chk("pp_mdr", 32'(bus.MD_READY), 32'd1);
    chk("pp_pend", bus.PENDING, 32'h0010_0000);
    port("dup_popB", 2);
    cyc(); drive_md(1'b0, 5'd0, 32'd0); #2;
    chk("pp_pend22", bus.PENDING, 32'h0040_0000);
    port("pp_popC", 2);
    cyc(); #2;
    chk("pp_pend0", bus.PENDING, 32'd0);
    port("pp_idle", 0);

    // WAW flag
    cyc(); drive_wb(1'b1, 5'd11, 32'h1111_1111); md_push(5'd10, 32'h1010_1010); #2;
    port("waw_wb11", 1);
    chk("waw_err0", 32'(bus.ERR_WAW), 32'd0);
    cyc(); drive_md(1'b0, 5'd0, 32'd0); drive_wb(1'b1, 5'd10, 32'hAAAA_AAAA); #2;
    port("waw_wb10", 1);
    chk("waw_pend", bus.PENDING, 32'h0000_0400);
    chk("waw_err1", 32'(bus.ERR_WAW), 32'd0);
    cyc(); drive_wb(1'b0, 5'd0, 32'd0); #2;
    chk("waw_set", 32'(bus.ERR_WAW), 32'd1);
    port("waw_md_x10", 2);
    cyc(); #2;
    chk("waw_sticky", 32'(bus.ERR_WAW), 32'd1);
    chk("waw_pend0", bus.PENDING, 32'd0);
    port("waw_idle", 0);

    // Reset mid-operation discards the queued entry
    cyc(); drive_wb(1'b1, 5'd12, 32'hC0C0_C0C0); drive_md(1'b1, 5'd13, 32'h1313_1313); #2;
    port("mid_wb12", 1);
    chk("mid_err", 32'(bus.ERR_WAW), 32'd1);
    cyc(); RESET = 1'b1; drive_wb(1'b0, 5'd0, 32'd0); drive_md(1'b0, 5'd0, 32'd0); #2;
    chk("mid_rst_we", 32'(bus.WRITEENABLE), 32'd0);
    chk("mid_rst_pend", bus.PENDING, 32'd0);
    chk("mid_rst_err", 32'(bus.ERR_WAW), 32'd1);
    cyc(); RESET = 1'b0; #2;
    chk("mid_rel_err", 32'(bus.ERR_WAW), 32'd0);
    chk("mid_rel_pend", bus.PENDING, 32'd0);
    chk("mid_rel_mdr", 32'(bus.MD_READY), 32'd1);
    port("mid_rel", 0);
    cyc(); #2;
    port("mid_rel2", 0);

    chk("sb_drained", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between two requesters. The pipeline WB stage has default priority. The multi-cycle M-extension (mul/div) unit writes through a DEPTH-entry FIFO. A starvation counter flips priority to the FIFO, and a PENDING mask lets decode stall reads of registers that still have queued writes.

Parameters:
DEPTH, 2, FIFO entries for mul/div results (power of 2, >=2)
STARVE_LIMIT, 4, consecutive non-granted cycles with FIFO non-empty before FIFO gets priority

Ports:
CLK  input  1  clock
RESET  input  1  synchronous, active-high reset
WB_VALID  input  1  WB stage has a write this cycle
WB_ADDR  input  5  WB destination register
WB_DATA  input  32  WB write data
WB_READY  output  1  WB write accepted this cycle; 0 means the pipeline must hold WB
MD_VALID  input  1  mul/div result available
MD_ADDR  input  5  mul/div destination register
MD_DATA  input  32  mul/div result
MD_READY  output  1  FIFO can accept (valid&ready = transfer)
WRITEENABLE  output  1  to register file
WRITEADDRESS  output  5  to register file
WRITEDATA  output  32  to register file
PENDING  output  32  bit i = some FIFO entry targets register i
ERR_WAW  output  1  sticky: WB wrote a register still pending in FIFO

Behaviour:
- Reset: RESET is synchronous and active-high; clock is CLK. On RESET at posedge: FIFO emptied, pointers/count=0, starve counter=0, state=WB_PRI, ERR_WAW=0.
- While RESET=1: WRITEENABLE=0 is forced combinationally. WRITEADDRESS=0, WRITEDATA=0, WB_READY=1, MD_READY=0, PENDING=0.
- Reset mid-operation: queued entries are discarded without being written.
- Write-port outputs are combinational from the current-cycle grant. The register file commits at the next posedge (0-cycle arbiter latency).
- Effective WB request: WB_VALID=1 and WB_ADDR!=0. WB_VALID with WB_ADDR=0 is a no-op with WB_READY=1.
- MD handshake: MD_READY=!full (not pop-aware, so full with simultaneous pop still gives MD_READY=0).
- MD transfer with MD_ADDR=0: accepted and dropped, never pushed.
- FIFO: circular, in-order. Pointers wrap modulo DEPTH. Push and pop in the same cycle are allowed when non-empty.
- State machine:
  - WB_PRI:
    - Effective WB request -> grant WB (WB_READY=1, write-port outputs = WB fields).
    - Else if FIFO non-empty -> grant FIFO head (pop).
    - Else WRITEENABLE=0, WRITEADDRESS=0, WRITEDATA=0.
  - MD_PRI:
    - FIFO head granted unconditionally.
    - WB_READY=0 whenever an effective WB request is present.
    - Exactly one grant, then -> WB_PRI.
  - Starve counter: increments each cycle the FIFO is non-empty and the head is not granted. Clears on any FIFO grant or when the FIFO is empty. When the counter == STARVE_LIMIT-1 and the head is again not granted -> next state MD_PRI, counter cleared.
  - MD_PRI is never entered with an empty FIFO.
- WB_READY=0 only in MD_PRI with an effective WB request. The pipeline holds WB_VALID, WB_ADDR and WB_DATA stable until accepted.
- PENDING: OR of one-hot(addr) over the current FIFO contents only (registered state). Bit 0 is always 0. An entry's bit clears in the cycle after it is popped. The same address queued twice keeps its bit set until both entries are popped.
- ERR_WAW: set at posedge when a WB grant has WB_ADDR whose PENDING bit is 1. Stays set until RESET. Write ordering is not corrected; decode must prevent this case using PENDING.

Test Plan:
- Reset: RESET=1 for 2 cycles with MD_VALID=1 -> WRITEENABLE=0, MD_READY=0, PENDING=0. After release, MD_READY=1 and FIFO empty.
- WB only: WB_VALID=1, WB_ADDR=5, WB_DATA=0xA5A5A5A5 -> same cycle WRITEENABLE=1, WRITEADDRESS=5, WRITEDATA=0xA5A5A5A5, WB_READY=1. After the edge, a register file read of x5 returns 0xA5A5A5A5.
- Idle-slot drain: push MD (addr 7, 0x12345678) with WB idle -> PENDING bit 7=1 the next cycle. That same cycle the write is x7 <= 0x12345678, and PENDING=0 the cycle after.
- Starvation: fill FIFO (addr 3 and 4), hold WB_VALID=1 to x9 continuously -> WB granted 4 cycles, then 1 cycle with WB_READY=0 and x3 written. Then WB is granted again for 4 cycles, then x4 is written. MD_READY is 0 while full, 1 after the first pop.
- x0 handling: MD push with addr 0 -> no FIFO entry and PENDING unchanged. WB_VALID with WB_ADDR=0 while FIFO holds addr 6 -> x6 written that cycle (WB_READY=1).
- WAW flag: FIFO holds addr 10, WB writes x10 in WB_PRI -> ERR_WAW=1 from the next cycle and stays 1 until RESET. The x10 FIFO entry is still written later.
